gecikmeli_bellek: RTL and testbench

Parametrised successor to the team's main memory model. It places a byte-addressed, word-organised RAM behind a valid/ready request channel and a valid/ready response channel. It adds configurable access latency, byte-masked writes, registered read data and an error response for out-of-range or misaligned addresses. It sits between the multi-cycle core's memory interface and the testbench/SoC. The core can therefore be exercised against non-zero memory latency and backpressure.

---
 rtl/gecikmeli_bellek_if.sv | 27 ++
 rtl/gecikmeli_bellek.sv | 116 +++++++++++
 tb/tb_gecikmeli_bellek.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gecikmeli_bellek_if.sv
// Request and response valid/ready channels of the latency memory model.
// The master drives requests and accepts responses; the slave is the memory.
interface gecikmeli_bellek_if #(
  parameter int unsigned ADRES_BIT = 32,
  parameter int unsigned VERI_BIT  = 32
);
  logic                  istek_gecerli;
  logic                  istek_hazir;
  logic [ADRES_BIT-1:0]  istek_adres;
  logic                  istek_yaz;
  logic [VERI_BIT-1:0]   istek_veri;
  logic [VERI_BIT/8-1:0] istek_maske;
  logic                  yanit_gecerli;
  logic                  yanit_hazir;
  logic [VERI_BIT-1:0]   yanit_veri;
  logic                  yanit_hata;

  modport master (
    output istek_gecerli, istek_adres, istek_yaz, istek_veri, istek_maske, yanit_hazir,
    input  istek_hazir, yanit_gecerli, yanit_veri, yanit_hata
  );

  modport slave (
    input  istek_gecerli, istek_adres, istek_yaz, istek_veri, istek_maske, yanit_hazir,
    output istek_hazir, yanit_gecerli, yanit_veri, yanit_hata
  );
endinterface

// File: rtl/gecikmeli_bellek.sv
// Word-organised RAM behind a valid/ready request/response pair, with a fixed
// access latency, byte-masked writes and an error response for bad addresses.
module gecikmeli_bellek #(
  parameter int unsigned          ADRES_BIT       = 32,
  parameter logic [ADRES_BIT-1:0] BASLANGIC_ADRES = 32'h8000_0000,
  parameter int unsigned          VERI_BIT        = 32,
  parameter int unsigned          BELLEK_SATIR    = 2048,
  parameter int unsigned          GECIKME         = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  gecikmeli_bellek_if.slave  bus
);
  localparam int unsigned BAYT  = VERI_BIT / 8;
  localparam int unsigned OFS   = $clog2(BAYT);
  localparam int unsigned IDX_W = (BELLEK_SATIR > 1) ? $clog2(BELLEK_SATIR) : 1;
  localparam int unsigned SW    = (GECIKME > 1) ? $clog2(GECIKME) : 1;

  // Range bounds carry one extra bit so a region ending at the top of the
  // address space does not wrap to zero.
  localparam logic [ADRES_BIT:0] ALT = {1'b0, BASLANGIC_ADRES};
  localparam logic [ADRES_BIT:0] UST = ALT + (ADRES_BIT+1)'(BELLEK_SATIR * BAYT);

  typedef enum logic [1:0] {BOSTA, BEKLE, YANIT} durum_t;

  durum_t                durum_q, durum_d;
  logic [SW-1:0]         sayac_q, sayac_d;
  logic [VERI_BIT-1:0]   yanit_veri_q, yanit_veri_d;
  logic                  yanit_hata_q, yanit_hata_d;

  logic [ADRES_BIT-1:0]  adres_q;
  logic                  yaz_q;
  logic [VERI_BIT-1:0]   veri_q;
  logic [BAYT-1:0]       maske_q;

  logic [VERI_BIT-1:0]   bellek [BELLEK_SATIR];

  logic                  kabul;
  logic                  erisim;
  logic                  hata;
  logic [ADRES_BIT-1:0]  fark;
  logic [IDX_W-1:0]      idx;

  assign kabul  = (durum_q == BOSTA) && bus.istek_gecerli;
  assign erisim = (durum_q == BEKLE) && (sayac_q == '0);

  assign hata = ({1'b0, adres_q} < ALT) || ({1'b0, adres_q} >= UST) ||
                (adres_q[OFS-1:0] != '0);
  assign fark = adres_q - BASLANGIC_ADRES;
  assign idx  = IDX_W'(fark >> OFS);

  assign bus.istek_hazir   = (durum_q == BOSTA);
  assign bus.yanit_gecerli = (durum_q == YANIT);
  assign bus.yanit_veri    = yanit_veri_q;
  assign bus.yanit_hata    = yanit_hata_q;

  always_comb begin
    durum_d      = durum_q;
    sayac_d      = sayac_q;
    yanit_veri_d = yanit_veri_q;
    yanit_hata_d = yanit_hata_q;
    unique case (durum_q)
      BOSTA: begin
        if (bus.istek_gecerli) begin
          sayac_d = SW'(GECIKME - 1);
          durum_d = BEKLE;
        end
      end
      BEKLE: begin
        if (sayac_q == '0) begin
          yanit_hata_d = hata;
          yanit_veri_d = (hata || yaz_q) ? '0 : bellek[idx];
          durum_d      = YANIT;
        end else begin
          sayac_d = sayac_q - SW'(1);
        end
      end
      YANIT: begin
        if (bus.yanit_hazir) durum_d = BOSTA;
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      durum_q      <= BOSTA;
      sayac_q      <= '0;
      yanit_veri_q <= '0;
      yanit_hata_q <= 1'b0;
    end else begin
      durum_q      <= durum_d;
      sayac_q      <= sayac_d;
      yanit_veri_q <= yanit_veri_d;
      yanit_hata_q <= yanit_hata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (kabul) begin
      adres_q <= bus.istek_adres;
      yaz_q   <= bus.istek_yaz;
      veri_q  <= bus.istek_veri;
      maske_q <= bus.istek_maske;
    end
  end

  // A reset on the access edge aborts the write, so rst_n gates the commit.
  always_ff @(posedge clk) begin
    if (erisim && rst_n && yaz_q && !hata) begin
      for (int k = 0; k < int'(BAYT); k++) begin
        if (maske_q[k]) bellek[idx][8*k +: 8] <= veri_q[8*k +: 8];
      end
    end
  end
endmodule

// File: tb/tb_gecikmeli_bellek.sv
// Randomised self-checking bench for gecikmeli_bellek: a 32-bit default
// instance and a 64-bit, single-wait-cycle, 16-word instance.
module tb_gecikmeli_bellek;
  localparam int G32 = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic rst64_n;
  int   n_kontrol = 0;
  int   n_hata    = 0;
  logic [63:0] ref_m [int];

  always #5 clk = ~clk;

  gecikmeli_bellek_if #(.ADRES_BIT(32), .VERI_BIT(32)) a32 ();
  gecikmeli_bellek_if #(.ADRES_BIT(32), .VERI_BIT(64)) a64 ();

  gecikmeli_bellek u_dut (.clk(clk), .rst_n(rst_n), .bus(a32));
  gecikmeli_bellek #(.VERI_BIT(64), .GECIKME(1), .BELLEK_SATIR(16)) u_dut64 (
    .clk(clk), .rst_n(rst64_n), .bus(a64));

  task automatic kontrol(input string etiket, input logic [63:0] gozlenen,
                         input logic [63:0] beklenen);
    n_kontrol++;
    if (gozlenen !== beklenen) begin
      n_hata++;
      $display("FAIL %s: gozlenen=%h beklenen=%h", etiket, gozlenen, beklenen);
    end
  endtask

  // Reference memory: ins 0 = 32-bit instance, ins 1 = 64-bit instance.
  function automatic void model(input int ins, input logic [31:0] adr, input logic yaz,
                                input logic [63:0] veri, input logic [7:0] maske,
                                output logic [63:0] cikis, output logic hata);
    longint bayt  = (ins == 0) ? 4 : 8;
    longint satir = (ins == 0) ? 2048 : 16;
    longint taban = 64'h8000_0000;
    longint a     = {32'h0, adr};
    longint idx;
    int     anahtar;
    logic [63:0] w;
    hata  = (a < taban) || (a >= taban + satir * bayt) || (a % bayt != 0);
    cikis = '0;
    if (!hata) begin
      idx     = (a - taban) / bayt;
      anahtar = ins * 100000 + int'(idx);
      w       = ref_m.exists(anahtar) ? ref_m[anahtar] : 64'h0;
      if (yaz) begin
        for (int k = 0; k < int'(bayt); k++)
          if (maske[k]) w[8*k +: 8] = veri[8*k +: 8];
        ref_m[anahtar] = w;
      end else begin
        cikis = w;
      end
    end
  endfunction

  task automatic kabul32(input logic [31:0] adr, input logic yaz, input logic [31:0] veri,
                         input logic [3:0] maske);
    int t = 0;
    a32.istek_gecerli = 1'b1;
    a32.istek_adres   = adr;
    a32.istek_yaz     = yaz;
    a32.istek_veri    = veri;
    a32.istek_maske   = maske;
    while (a32.istek_hazir !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    kontrol("istek_hazir", a32.istek_hazir, 1);
    @(posedge clk); #1;
    a32.istek_gecerli = 1'b0;
  endtask

  task automatic istek32(input logic [31:0] adr, input logic yaz, input logic [31:0] veri,
                         input logic [3:0] maske, input int bp, output logic [31:0] gozlenen);
    logic [63:0] bek_veri;
    logic        bek_hata;
    model(0, adr, yaz, {32'h0, veri}, {4'h0, maske}, bek_veri, bek_hata);
    kabul32(adr, yaz, veri, maske);
    a32.istek_gecerli = (bp > 0);
    a32.istek_adres   = $urandom;
    a32.istek_yaz     = 1'($urandom);
    a32.istek_veri    = $urandom;
    a32.istek_maske   = 4'($urandom);
    kontrol("kabul_sonrasi_hazir", a32.istek_hazir, 0);
    kontrol("yanit_erken", a32.yanit_gecerli, 0);
    repeat (G32 - 1) begin
      @(posedge clk); #1;
      kontrol("yanit_erken", a32.yanit_gecerli, 0);
    end
    @(posedge clk); #1;
    kontrol("yanit_gecerli", a32.yanit_gecerli, 1);
    kontrol("yanit_veri", a32.yanit_veri, bek_veri);
    kontrol("yanit_hata", a32.yanit_hata, bek_hata);
    gozlenen = a32.yanit_veri;
    repeat (bp) begin
      @(posedge clk); #1;
      kontrol("bp_gecerli", a32.yanit_gecerli, 1);
      kontrol("bp_veri", a32.yanit_veri, bek_veri);
      kontrol("bp_hata", a32.yanit_hata, bek_hata);
      kontrol("bp_istek_hazir", a32.istek_hazir, 0);
    end
    a32.istek_gecerli = 1'b0;
    a32.yanit_hazir   = 1'b1;
    @(posedge clk); #1;
    a32.yanit_hazir = 1'b0;
    kontrol("el_sikisma_gecerli", a32.yanit_gecerli, 0);
    kontrol("el_sikisma_hazir", a32.istek_hazir, 1);
  endtask

  task automatic istek64(input logic [31:0] adr, input logic yaz, input logic [63:0] veri,
                         input logic [7:0] maske, output logic [63:0] gozlenen);
    logic [63:0] bek_veri;
    logic        bek_hata;
    int          t = 0;
    model(1, adr, yaz, veri, maske, bek_veri, bek_hata);
    a64.istek_gecerli = 1'b1;
    a64.istek_adres   = adr;
    a64.istek_yaz     = yaz;
    a64.istek_veri    = veri;
    a64.istek_maske   = maske;
    while (a64.istek_hazir !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    kontrol("istek_hazir64", a64.istek_hazir, 1);
    @(posedge clk); #1;
    a64.istek_gecerli = 1'b0;
    a64.istek_veri    = {$urandom, $urandom};
    kontrol("yanit_erken64", a64.yanit_gecerli, 0);
    @(posedge clk); #1;
    kontrol("yanit_gecerli64", a64.yanit_gecerli, 1);
    kontrol("yanit_veri64", a64.yanit_veri, bek_veri);
    kontrol("yanit_hata64", a64.yanit_hata, bek_hata);
    gozlenen = a64.yanit_veri;
    a64.yanit_hazir = 1'b1;
    @(posedge clk); #1;
    a64.yanit_hazir = 1'b0;
    kontrol("el_sikisma_hazir64", a64.istek_hazir, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL zaman_asimi: gozlenen=bitmedi beklenen=bitti");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] o32;
    logic [63:0] o64;
    logic [63:0] bek64;
    logic        bek_h;
    logic [31:0] adr;
    int          kabul_c[$];

    rst_n = 1'b0; rst64_n = 1'b0;
    a32.istek_gecerli = 0; a32.istek_adres = '0; a32.istek_yaz = 0;
    a32.istek_veri = '0; a32.istek_maske = '0; a32.yanit_hazir = 0;
    a64.istek_gecerli = 0; a64.istek_adres = '0; a64.istek_yaz = 0;
    a64.istek_veri = '0; a64.istek_maske = '0; a64.yanit_hazir = 0;
    repeat (3) @(posedge clk);
    #1;
    kontrol("rst_istek_hazir", a32.istek_hazir, 1);
    kontrol("rst_yanit_gecerli", a32.yanit_gecerli, 0);
    kontrol("rst_yanit_veri", a32.yanit_veri, 0);
    kontrol("rst_yanit_hata", a32.yanit_hata, 0);
    kontrol("rst_istek_hazir64", a64.istek_hazir, 1);
    kontrol("rst_yanit_gecerli64", a64.yanit_gecerli, 0);
    rst_n = 1'b1; rst64_n = 1'b1;
    @(posedge clk); #1;

    istek32(32'h8000_0010, 1, 32'hDEAD_BEEF, 4'hF, 0, o32);
    istek32(32'h8000_0010, 0, 32'h0, 4'h0, 0, o32);
    kontrol("okuma_deadbeef", o32, 32'hDEAD_BEEF);

    istek32(32'h8000_0020, 1, 32'h1122_3344, 4'hF, 0, o32);
    istek32(32'h8000_0020, 1, 32'hAABB_CCDD, 4'b0101, 0, o32);
    istek32(32'h8000_0020, 0, 32'h0, 4'hF, 0, o32);
    kontrol("bayt_maske", o32, 32'h11BB_33DD);
    istek32(32'h8000_0020, 1, 32'hFFFF_FFFF, 4'h0, 0, o32);

    istek32(32'h7FFF_FFFC, 0, 32'h0, 4'hF, 0, o32);
    kontrol("hata_alt_veri", o32, 0);
    istek32(32'h8000_2000, 1, 32'h1234_5678, 4'hF, 0, o32);
    istek32(32'h8000_0002, 0, 32'h0, 4'hF, 0, o32);
    istek32(32'h8000_0012, 1, 32'h0BAD_0BAD, 4'hF, 0, o32);
    istek32(32'h8000_1FFC, 1, 32'h0F0F_0F0F, 4'hF, 0, o32);
    istek32(32'h8000_0010, 0, 32'h0, 4'hF, 0, o32);
    kontrol("hata_sonrasi_okuma", o32, 32'hDEAD_BEEF);

    istek32(32'h8000_0010, 0, 32'h0, 4'hF, 10, o32);

    // Reset while the write is still waiting.
    kabul32(32'h8000_0000, 1, 32'h5555_5555, 4'hF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    kontrol("rst_bekle_hazir", a32.istek_hazir, 1);
    repeat (4) begin
      kontrol("rst_bekle_yanit_yok", a32.yanit_gecerli, 0);
      @(posedge clk); #1;
    end
    istek32(32'h8000_0000, 0, 32'h0, 4'hF, 0, o32);
    kontrol("rst_bekle_okuma", o32, 0);

    // Reset while the write response is pending: the write stays committed.
    model(0, 32'h8000_0044, 1, 64'hCAFE_F00D, 8'h0F, bek64, bek_h);
    kabul32(32'h8000_0044, 1, 32'hCAFE_F00D, 4'hF);
    repeat (G32) @(posedge clk);
    #1;
    kontrol("rst_yanit_once", a32.yanit_gecerli, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    kontrol("rst_yanit_dusuruldu", a32.yanit_gecerli, 0);
    kontrol("rst_yanit_veri", a32.yanit_veri, 0);
    istek32(32'h8000_0044, 0, 32'h0, 4'hF, 0, o32);
    kontrol("rst_yanit_okuma", o32, 32'hCAFE_F00D);

    for (int i = 0; i < 40; i++) begin
      adr = 32'h8000_0040 + 32'($urandom_range(0, 15) * 4);
      case ($urandom_range(0, 9))
        0: adr = 32'h7FFF_FFFC;
        1: adr = 32'h8000_2000;
        2: adr = adr | 32'($urandom_range(1, 3));
        3: adr = 32'hFFFF_FFFC;
        default: ;
      endcase
      istek32(adr, 1'($urandom), $urandom, 4'($urandom), int'($urandom_range(0, 3)), o32);
    end

    istek64(32'h8000_0078, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, o64);
    istek64(32'h8000_0078, 0, 64'h0, 8'h0, o64);
    kontrol("son_satir64", o64, 64'h0123_4567_89AB_CDEF);
    istek64(32'h8000_0078, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, o64);
    istek64(32'h8000_0080, 1, 64'h0, 8'hFF, o64);
    istek64(32'h8000_0004, 1, 64'h0, 8'hFF, o64);
    istek64(32'h8000_0080, 0, 64'h0, 8'hFF, o64);
    istek64(32'h8000_0078, 0, 64'h0, 8'h0, o64);
    kontrol("maske64", o64, 64'h0123_4567_FFFF_FFFF);

    // Back-to-back reads with the response side always ready.
    model(1, 32'h8000_0078, 0, 64'h0, 8'h0, bek64, bek_h);
    a64.istek_gecerli = 1'b1; a64.istek_adres = 32'h8000_0078; a64.istek_yaz = 1'b0;
    a64.yanit_hazir = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (a64.istek_hazir === 1'b1) kabul_c.push_back(c);
      if (a64.yanit_gecerli === 1'b1) kontrol("ardisik_veri64", a64.yanit_veri, bek64);
      @(posedge clk); #1;
    end
    a64.istek_gecerli = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    a64.yanit_hazir = 1'b0;
    kontrol("ardisik_sayi", 64'(kabul_c.size()), 5);
    for (int j = 1; j < kabul_c.size(); j++)
      kontrol("ardisik_aralik", 64'(kabul_c[j] - kabul_c[j-1]), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_kontrol, n_hata);
    $finish;
  end
endmodule
